// File: rtl/alu_sequencer.sv
// Multi-cycle register-file sequencer driving an external combinational ALU.
// Optional Z/N flags are enabled by defining ALU_SEQUENCER_FLAGS_EN.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [RW-1:0]     instr_rx,
  input  logic [RW-1:0]     instr_ry,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_r,
  output logic              done,
  input  logic [RW-1:0]     rd_sel,
  output logic [DATA_W-1:0] rd_data
`ifdef ALU_SEQUENCER_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [1:0] OP_LI = 2'b11;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [1:0]        op_q;
  logic [RW-1:0]     rx_q;
  logic [RW-1:0]     ry_q;

`ifdef ALU_SEQUENCER_FLAGS_EN
  logic z_q;
  logic n_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
`endif

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign rd_data = regs_q[rd_sel];

  // Next state and per-state outputs; ALU idles with op 11 outside EXEC
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_op      = 2'b11;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = (instr_op == OP_LI) ? WB : FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        alu_op  = op_q;
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus datapath; reset wins over any handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_LI;
      rx_q    <= '0;
      ry_q    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
`ifdef ALU_SEQUENCER_FLAGS_EN
      z_q <= 1'b0;
      n_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            op_q <= instr_op;
            rx_q <= instr_rx;
            ry_q <= instr_ry;
            if (instr_op == OP_LI) begin
              res_q <= instr_imm;
            end
          end
        end
        FETCH: begin
          a_q <= regs_q[rx_q];
          b_q <= regs_q[ry_q];
        end
        EXEC: res_q <= alu_r;
        WB: begin
          regs_q[rx_q] <= res_q;
`ifdef ALU_SEQUENCER_FLAGS_EN
          if (op_q != OP_LI) begin
            z_q <= (res_q == '0);
            n_q <= res_q[DATA_W-1];
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model.
// Flag checks are compiled in when ALU_SEQUENCER_FLAGS_EN is defined.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_op;
  logic [2:0]  instr_rx;
  logic [2:0]  instr_ry;
  logic [15:0] instr_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_r;
  logic        done;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
`ifdef ALU_SEQUENCER_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.DATA_W(16), .NREGS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rx    (instr_rx),
    .instr_ry    (instr_ry),
    .instr_imm   (instr_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_r       (alu_r),
    .done        (done),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data)
`ifdef ALU_SEQUENCER_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_n      (flag_n)
`endif
  );

  always #5 clock = ~clock;

  // external combinational ALU
  always_comb begin
    alu_r = 16'h0000;
    case (alu_op)
      2'b00:   alu_r = alu_a + alu_b;
      2'b01:   alu_r = alu_a - alu_b;
      2'b10:   alu_r = ~(alu_a & alu_b);
      default: alu_r = 16'h0000;
    endcase
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [2:0] r,
                    input logic [15:0] exp,
                    input string tag);
    rd_sel = r;
    #1;
    check(tag, rd_data, exp);
  endtask

  // issue one instruction, measure latency, capture EXEC operands
  // and the WB-cycle read of the destination register
  task automatic send(input logic [1:0] op,
                      input logic [2:0] rx,
                      input logic [2:0] ry,
                      input logic [15:0] imm,
                      output int lat,
                      output logic [15:0] oa,
                      output logic [15:0] ob,
                      output logic [1:0] oo,
                      output logic [15:0] wb_old);
    rd_sel = rx;
    check("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rx    = rx;
    instr_ry    = ry;
    instr_imm   = imm;
    tick();
    instr_valid = 1'b0;
    instr_op    = 2'b10;
    instr_rx    = ~rx;
    instr_ry    = ~ry;
    instr_imm   = 16'hDEAD;
    lat = 1;
    oa = 16'h0;
    ob = 16'h0;
    oo = 2'b11;
    wb_old = 16'h0;
    while (!done && lat < 10) begin
      if (alu_op != 2'b11) begin
        oa = alu_a;
        ob = alu_b;
        oo = alu_op;
      end
      tick();
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
    wb_old = rd_data;
    tick();
    check("done_one_cycle", done, 0);
  endtask

  int          lat;
  logic [15:0] oa, ob, wbo;
  logic [1:0]  oo;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] imm;
  } ins_t;

  ins_t stream [3];
  int   idx, low_cnt, done_cnt, iters, seen_done;
  logic rdy;

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 2'b00;
    instr_rx    = 3'd0;
    instr_ry    = 3'd0;
    instr_imm   = 16'h0;
    rd_sel      = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_done", done, 0);
    check("rst_aluop", alu_op, 2'b11);
    check("rst_ready", instr_ready, 1);
    check("rst_alu_a", alu_a, 16'h0);
    check("rst_alu_b", alu_b, 16'h0);
    rd(3'd0, 16'h0, "rst_r0");
`ifdef ALU_SEQUENCER_FLAGS_EN
    check("rst_fz", flag_z, 0);
    check("rst_fn", flag_n, 0);
`endif

    // load-immediates
    send(2'b11, 3'd1, 3'd0, 16'h0005, lat, oa, ob, oo, wbo);
    check("li1_lat", lat, 1);
    check("li1_wb_old", wbo, 16'h0000);
    rd(3'd1, 16'h0005, "li1_r1");
    send(2'b11, 3'd2, 3'd0, 16'h0003, lat, oa, ob, oo, wbo);
    check("li2_lat", lat, 1);
    rd(3'd2, 16'h0003, "li2_r2");
    rd(3'd1, 16'h0005, "li2_r1");

    // add R1,R2
    send(2'b00, 3'd1, 3'd2, 16'h0, lat, oa, ob, oo, wbo);
    check("add_lat", lat, 3);
    check("add_a", oa, 16'h0005);
    check("add_b", ob, 16'h0003);
    check("add_op", oo, 2'b00);
    check("add_wb_old", wbo, 16'h0005);
    rd(3'd1, 16'h0008, "add_r1");
    check("idle_aluop", alu_op, 2'b11);

    // sub R3,R4 with R3=0, R4=1
    send(2'b11, 3'd4, 3'd0, 16'h0001, lat, oa, ob, oo, wbo);
    send(2'b01, 3'd3, 3'd4, 16'h0, lat, oa, ob, oo, wbo);
    check("sub_lat", lat, 3);
    check("sub_op", oo, 2'b01);
    rd(3'd3, 16'hFFFF, "sub_r3");
`ifdef ALU_SEQUENCER_FLAGS_EN
    check("sub_fn", flag_n, 1);
    check("sub_fz", flag_z, 0);
`endif

    // nand R5,R5 with R5=FFFF
    send(2'b11, 3'd5, 3'd0, 16'hFFFF, lat, oa, ob, oo, wbo);
    send(2'b10, 3'd5, 3'd5, 16'h0, lat, oa, ob, oo, wbo);
    check("nand_a", oa, 16'hFFFF);
    check("nand_b", ob, 16'hFFFF);
    rd(3'd5, 16'h0000, "nand_r5");
`ifdef ALU_SEQUENCER_FLAGS_EN
    check("nand_fz", flag_z, 1);
    check("nand_fn", flag_n, 0);
`endif
    // load-immediate must not disturb flags
    send(2'b11, 3'd6, 3'd0, 16'h8000, lat, oa, ob, oo, wbo);
    rd(3'd6, 16'h8000, "li_r6");
`ifdef ALU_SEQUENCER_FLAGS_EN
    check("li_fz_hold", flag_z, 1);
    check("li_fn_hold", flag_n, 0);
`endif

    // valid held high across a stream: R7=1; R7+=R7 twice; R0=9
    send(2'b11, 3'd7, 3'd0, 16'h0001, lat, oa, ob, oo, wbo);
    stream[0] = '{2'b00, 3'd7, 3'd7, 16'h0};
    stream[1] = '{2'b00, 3'd7, 3'd7, 16'h0};
    stream[2] = '{2'b11, 3'd0, 3'd0, 16'h0009};
    idx = 0;
    low_cnt = 0;
    done_cnt = 0;
    iters = 0;
    while (idx < 3 && iters < 40) begin
      done_cnt += int'(done);
      rdy = instr_ready;
      if (!rdy) low_cnt++;
      instr_valid = 1'b1;
      instr_op    = stream[idx].op;
      instr_rx    = stream[idx].rx;
      instr_ry    = stream[idx].ry;
      instr_imm   = stream[idx].imm;
      tick();
      if (rdy) idx++;
      iters++;
    end
    check("stream_accepts", idx, 3);
    done_cnt += int'(done);
    instr_valid = 1'b0;
    tick();
    check("stream_done_cnt", done_cnt, 3);
    check("stream_ready_low", low_cnt, 6);
    rd(3'd7, 16'h0004, "stream_r7");
    rd(3'd0, 16'h0009, "stream_r0");

    // reset during EXEC of add R1,R2 (R1=8, R2=3)
    rd_sel = 3'd1;
    instr_valid = 1'b1;
    instr_op    = 2'b00;
    instr_rx    = 3'd1;
    instr_ry    = 3'd2;
    tick();
    instr_valid = 1'b0;
    tick();
    check("abort_in_exec", alu_op, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ready", instr_ready, 1);
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      seen_done += int'(done);
      tick();
    end
    check("abort_no_done", seen_done, 0);
    rd(3'd1, 16'h0000, "abort_r1");
    rd(3'd7, 16'h0000, "abort_r7");
    check("abort_alu_a", alu_a, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
